// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, issues credit-limited requests to a
// variable-latency instruction memory and buffers in-order responses for decode.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);
  localparam int             PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             misalign_q, misalign_d;
  logic             run_q;
  logic [31:0]      data_mem_q [FIFO_DEPTH];
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];

  logic gnt_s, rsp_s, drop_rsp_s, push_s, pop_s;

  // A response is only owed a FIFO slot if it was counted as outstanding when requested.
  assign imem_req     = run_q && !redirect_valid &&
                        (({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C);
  assign imem_addr    = pc_q;
  assign gnt_s        = imem_req && imem_gnt;
  assign rsp_s        = imem_rvalid && (out_q != CNT_ZERO);
  assign drop_rsp_s   = rsp_s && (drop_q != CNT_ZERO);
  assign push_s       = rsp_s && !drop_rsp_s && !redirect_valid;
  assign pop_s        = instr_valid && instr_ready;
  assign instr_valid  = (cnt_q != CNT_ZERO);
  assign instr        = instr_valid ? data_mem_q[rd_q] : 32'h0000_0000;
  assign instr_pc     = instr_valid ? pc_mem_q[rd_q]   : 32'h0000_0000;
  assign misalign_err = misalign_q;

  // Next-state for PC, counters and FIFO pointers.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    misalign_d = 1'b0;

    case ({gnt_s, rsp_s})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase

    if (redirect_valid) begin
      // Every response still in flight after this edge belongs to the old path.
      pc_d       = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
      drop_d     = rsp_s ? (out_q - CNT_ONE) : out_q;
      cnt_d      = CNT_ZERO;
      wr_d       = PTR_ZERO;
      rd_d       = PTR_ZERO;
    end else begin
      if (gnt_s) begin
        pc_d = pc_q + 32'd4;
      end else begin
        pc_d = pc_q;
      end
      if (drop_rsp_s) begin
        drop_d = drop_q - CNT_ONE;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        wr_d     = wr_q + PTR_ONE;
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else begin
        wr_d     = wr_q;
        rsp_pc_d = rsp_pc_q;
      end
      if (pop_s) begin
        rd_d = rd_q + PTR_ONE;
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
      cnt_q      <= CNT_ZERO;
      wr_q       <= PTR_ZERO;
      rd_q       <= PTR_ZERO;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      run_q      <= 1'b1;
    end
  end

  // Instruction buffer storage: word and its PC written together on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i]   <= 32'h0000_0000;
      end
    end else if (push_s) begin
      data_mem_q[wr_q] <= imem_rdata;
      pc_mem_q[wr_q]   <= rsp_pc_q;
    end else begin
      data_mem_q[wr_q] <= data_mem_q[wr_q];
      pc_mem_q[wr_q]   <= pc_mem_q[wr_q];
    end
  end

  rv32i_fetch_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .imem_addr   (imem_addr),
    .push_s      (push_s),
    .pop_s       (pop_s),
    .cnt_q       (cnt_q),
    .out_q       (out_q),
    .drop_q      (drop_q)
  );
endmodule

// Simulation-only checks on fetch internals; produces no logic.
module rv32i_fetch_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             imem_rvalid,
  input logic [31:0]      imem_addr,
  input logic             push_s,
  input logic             pop_s,
  input logic [CNT_W-1:0] cnt_q,
  input logic [CNT_W-1:0] out_q,
  input logic [CNT_W-1:0] drop_q
);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_s && !pop_s && ({1'b0, cnt_q} == DEPTH_C)))
    else $error("instruction buffer written while full");
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n) drop_q <= out_q)
    else $error("drop count exceeds outstanding count");
  a_addr_align: assert property (@(posedge clk) disable iff (!rst_n) imem_addr[1:0] == 2'b00)
    else $error("fetch address not word aligned");
  c_spurious_rsp: cover property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid && (out_q == {CNT_W{1'b0}}));
endmodule

// File: tb/tb_rv32i_fetch.sv
// Randomised scoreboard bench for rv32i_fetch: an epoch-tagged memory model
// predicts which fetched words reach decode, a monitor checks them in order.
module tb_rv32i_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid, instr_ready = 1'b0, misalign_err;
  logic [31:0] instr, instr_pc;

  rv32i_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; bit counted; int due; } mreq_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; int avail; } exp_t;

  mreq_t       pend_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, epoch = 0, last_due = 0;
  logic [31:0] model_pc = RESET_PC;
  bit          run_m = 1'b0, exp_mis = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC001_D00D;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the request-side model.
  task automatic cycle(input bit rst, input bit rd, input logic [31:0] rpc,
                       input bit gnt, input bit rdy, input int lat);
    int    outstanding;
    int    d;
    bit    deliver;
    mreq_t m;
    @(posedge clk);
    #1;
    cyc++;
    run_m          = (rst_n === 1'b1) && !rst;
    rst_n          = !rst;
    redirect_valid = rd && !rst;
    redirect_pc    = rpc;
    imem_gnt       = gnt;
    instr_ready    = rdy;
    deliver        = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    imem_rvalid    = deliver;
    imem_rdata     = deliver ? mem_word(pend_q[0].addr) : 32'h0;
    if (rst) begin
      exp_q.delete();
      epoch++;
      model_pc = RESET_PC;
      exp_mis  = 1'b0;
      foreach (pend_q[i]) pend_q[i].counted = 1'b0;
    end
    #1;
    outstanding = 0;
    foreach (pend_q[i]) if (pend_q[i].counted) outstanding++;
    check1("imem_req", imem_req,
           run_m && !redirect_valid && ((outstanding + exp_q.size()) < DEPTH));
    check32("imem_addr", imem_addr, model_pc);
    check1("misalign_err", misalign_err, exp_mis);
    exp_mis = 1'b0;
    if (deliver) begin
      m = pend_q.pop_front();
      if ((m.epoch == epoch) && !redirect_valid && !rst)
        exp_q.push_back('{data: mem_word(m.addr), pc: m.addr, avail: cyc + 1});
    end
    if (imem_req && imem_gnt) begin
      d = cyc + ((lat < 1) ? 1 : lat);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_q.push_back('{addr: model_pc, epoch: epoch, counted: 1'b1, due: d});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      epoch++;
      model_pc = {rpc[31:2], 2'b00};
      exp_mis  = |rpc[1:0];
    end
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    while ((pend_q.size() > 0) && (n < 20)) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
      n++;
    end
    if (pend_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL reset_drain: %0d responses still pending, required 0", pend_q.size());
      pend_q.delete();
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
  endtask

  // Monitor: mid-cycle, compare the decode-side output with the scoreboard head.
  always @(negedge clk) begin
    if ((exp_q.size() == 0) || (exp_q[0].avail > cyc)) begin
      check1("instr_valid_idle", instr_valid, 1'b0);
      check32("instr_idle", instr, 32'h0);
      check32("instr_pc_idle", instr_pc, 32'h0);
    end else begin
      check1("instr_valid", instr_valid, 1'b1);
    end
    if (instr_valid && instr_ready && rst_n) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_instr: got pc %h, expected no instruction (cycle %0d)",
                 instr_pc, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check32("instr", instr, mon_e.data);
        check32("instr_pc", instr_pc, mon_e.pc);
      end
    end
    if (redirect_valid) exp_q.delete();
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit          rd;
    logic [31:0] t;
    #1 rst_n = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    // Single-cycle memory, decode always ready.
    repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Stalled decode from a fresh reset, then release.
    do_reset();
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Two slow requests in flight, then redirect to 0x100.
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1);
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Redirect while a response and a decode transfer happen in the same cycle.
    cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Misaligned target, then a target that wraps past the top of memory.
    cycle(1'b0, 1'b1, 32'h0000_0206, 1'b1, 1'b1, 1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Reset with two requests in flight whose responses land after release.
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5);
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Random traffic: grants, stalls, latencies and redirects.
    repeat (3000) begin
      rd = ($urandom_range(0, 29) == 0);
      t  = $urandom;
      if ($urandom_range(0, 7) == 0) t[31:8] = 24'hFF_FFFF;
      else t[31:12] = 20'h0_0000;
      cycle(1'b0, rd, t, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            $urandom_range(1, 4));
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
